// File: rtl/etapa_fetch.sv
// Instruction fetch stage: PC, req/ack memory reads and a small instruction FIFO feeding IF/ID.
// Optional halt-on-opcode-0xF detection is compiled in with `define IF_HALT_DET_EN.
module etapa_fetch #(
    parameter int PC_W       = 8,
    parameter int INSTR_W    = 14,
    parameter int FIFO_DEPTH = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    output logic               mem_req,
    output logic [PC_W-1:0]    mem_addr,
    input  logic               mem_ack,
    input  logic [INSTR_W-1:0] mem_data,
    input  logic               stall_in,
    input  logic               branch_taken,
    input  logic [PC_W-1:0]    branch_target,
    output logic [INSTR_W-1:0] instr_out,
    output logic [PC_W-1:0]    pc_out,
    output logic               valid_out,
    output logic               halted
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

`ifdef IF_HALT_DET_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_HALT = 2'd2} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1} state_t;
`endif

    state_t state;
    state_t state_next;

    logic [INSTR_W-1:0] fifo_instr [FIFO_DEPTH];
    logic [PC_W-1:0]    fifo_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   count_next;
    logic [PC_W-1:0]    pc;
    logic [PC_W-1:0]    pc_next;
    logic               squash;
    logic               squash_next;

    logic               ack_eff;
    logic               push;
    logic               pop;
    logic               outstanding;
    logic               halt_next;
    logic               issue;
    logic               req_next;

    // Branch dominates push and pop; a squashed ack completes the bus cycle but carries no data.
    always_comb begin
        ack_eff     = mem_req & mem_ack;
        push        = ack_eff & ~squash & ~branch_taken;
        pop         = (count != '0) & ~stall_in & ~branch_taken;
        outstanding = mem_req & ~mem_ack;

        count_next = count;
        if (branch_taken) begin
            count_next = '0;
        end else if (push && !pop) begin
            count_next = count + CNT_W'(1);
        end else if (pop && !push) begin
            count_next = count - CNT_W'(1);
        end

        pc_next = pc;
        if (branch_taken) begin
            pc_next = branch_target;
        end else if (push) begin
            pc_next = pc + PC_W'(1);
        end

        squash_next = squash;
        if (branch_taken && outstanding) begin
            squash_next = 1'b1;
        end else if (ack_eff) begin
            squash_next = 1'b0;
        end
    end

    // Next-state logic; issuing looks at the state after this edge so a branch out of halt can fetch at once.
    always_comb begin
`ifdef IF_HALT_DET_EN
        halt_next = ~branch_taken &
                    ((push && (mem_data[INSTR_W-1:INSTR_W-4] == 4'hF)) || (state == S_HALT));
`else
        halt_next = 1'b0;
`endif
        issue    = fetch_en & ~halt_next & ~outstanding & (count_next < CNT_W'(FIFO_DEPTH));
        req_next = outstanding | issue;

        state_next = req_next ? S_WAIT : S_IDLE;
`ifdef IF_HALT_DET_EN
        if (halt_next) begin
            state_next = S_HALT;
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc       <= '0;
            count    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            squash   <= 1'b0;
            mem_req  <= 1'b0;
            mem_addr <= '0;
        end else begin
            pc      <= pc_next;
            count   <= count_next;
            squash  <= squash_next;
            mem_req <= req_next;
            if (issue) begin
                mem_addr <= pc_next;
            end
            if (branch_taken) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push) begin
                    wr_ptr <= wr_ptr + PTR_W'(1);
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + PTR_W'(1);
                end
            end
        end
    end

    // Storage carries data only; occupancy is tracked by count, so no reset is needed here.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_instr[wr_ptr] <= mem_data;
            fifo_pc[wr_ptr]    <= mem_addr;
        end
    end

    always_comb begin
        valid_out = (count != '0);
        instr_out = valid_out ? fifo_instr[rd_ptr] : '0;
        pc_out    = valid_out ? fifo_pc[rd_ptr] : '0;
`ifdef IF_HALT_DET_EN
        halted    = (state == S_HALT);
`else
        halted    = 1'b0;
`endif
    end

endmodule
